// File: rtl/alu_pkg.sv
// Shared types for the pipelined Hack ALU: FSM states, control-bit bundle
// and the named control patterns used by benches and callers.
package alu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } ctrl_t;

  localparam ctrl_t ZERO      = 6'b101010;
  localparam ctrl_t ONE       = 6'b111111;
  localparam ctrl_t X_PLUS_Y  = 6'b000010;
  localparam ctrl_t X_MINUS_Y = 6'b010011;
  localparam ctrl_t X_AND_Y   = 6'b000000;

  function automatic ctrl_t pack_ctrl(input logic zx, input logic nx,
                                      input logic zy, input logic ny,
                                      input logic f, input logic no);
    ctrl_t c;
    c.zx = zx;
    c.nx = nx;
    c.zy = zy;
    c.ny = ny;
    c.f  = f;
    c.no = no;
    return c;
  endfunction

endpackage

// File: rtl/pipe_alu_if.sv
// Request/response bundle of pipe_alu: valid/ready operation channel in,
// valid/ready registered result channel out, plus the busy status.
interface pipe_alu_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx, nx, zy, ny, f, no;
  logic             mul;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             busy;

  modport master (
    output in_valid, x, y, zx, nx, zy, ny, f, no, mul, out_ready,
    input  in_ready, out_valid, out, zr, ng, busy
  );

  modport slave (
    input  in_valid, x, y, zx, nx, zy, ny, f, no, mul, out_ready,
    output in_ready, out_valid, out, zr, ng, busy
  );

endinterface

// File: rtl/alu_core.sv
// Combinational Hack function: operand preprocessing, add/and (or an external
// product when use_prod is set), output inversion and zr/ng flags. No state.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  ctrl_t            ctrl,
  input  logic             use_prod,
  input  logic [WIDTH-1:0] prod,
  output logic [WIDTH-1:0] xp,
  output logic [WIDTH-1:0] yp,
  output logic [WIDTH-1:0] res,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] raw;

  always_comb begin
    xp = ctrl.zx ? '0 : x;
    if (ctrl.nx) xp = ~xp;
    yp = ctrl.zy ? '0 : y;
    if (ctrl.ny) yp = ~yp;

    if (use_prod)    raw = prod;
    else if (ctrl.f) raw = xp + yp;
    else             raw = xp & yp;

    res = ctrl.no ? ~raw : raw;
  end

  assign zr = (res == '0);
  assign ng = res[WIDTH-1];

endmodule

// File: rtl/pipe_alu.sv
// Hack ALU with registered result: ALU ops latency 1, shift-add multiply latency WIDTH+1.
// in_ready drops while multiplying or while a result is held with out_ready low.
module pipe_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic        clock,
  input  logic        reset,
  pipe_alu_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  ctrl_t            ctrl_in, ctrl_q, core_ctrl;
  logic             mul_sel, accept, mul_done, load, in_mul;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xp, yp, res;
  logic             res_zr, res_ng;
  logic [WIDTH-1:0] out_q;
  logic             zr_q, ng_q, ov_q;

  assign ctrl_in  = pack_ctrl(bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no);
  assign mul_sel  = (MUL_EN != 0) && bus.mul;
  assign accept   = bus.in_valid && bus.in_ready;
  assign in_mul   = (state == MUL);
  assign mul_done = in_mul && (cnt == CW'(WIDTH - 1));
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign load     = (accept && !mul_sel) || mul_done;

  // While multiplying, the core only applies the captured 'no' to the product.
  assign core_ctrl = in_mul ? ctrl_q : ctrl_in;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .x        (bus.x),
    .y        (bus.y),
    .ctrl     (core_ctrl),
    .use_prod (in_mul),
    .prod     (acc_nxt),
    .xp       (xp),
    .yp       (yp),
    .res      (res),
    .zr       (res_zr),
    .ng       (res_ng)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && mul_sel) state_nxt = MUL;
      MUL:     if (mul_done)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state == MUL);
    bus.in_ready = (state == IDLE) && (!ov_q || bus.out_ready);
  end

  // One multiplier bit per cycle; operands are the preprocessed x', y'.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      ctrl_q <= '0;
    end else if (accept && mul_sel) begin
      mcand  <= xp;
      mplier <= yp;
      acc    <= '0;
      cnt    <= '0;
      ctrl_q <= ctrl_in;
    end else if (in_mul) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      zr_q  <= 1'b1;
      ng_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else if (load) begin
      out_q <= res;
      zr_q  <= res_zr;
      ng_q  <= res_ng;
      ov_q  <= 1'b1;
    end else if (bus.out_ready) begin
      ov_q  <= 1'b0;
    end
  end

  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.out_valid = ov_q;

endmodule

// File: tb/tb_pipe_alu.sv
// Scoreboard bench for pipe_alu: 16-bit multiply-enabled instance with random
// traffic, plus an 8-bit instance built without the multiplier.
module tb_pipe_alu;
  import alu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  pipe_alu_if #(.WIDTH(16)) b16 ();
  pipe_alu_if #(.WIDTH(8))  b8 ();

  pipe_alu #(.WIDTH(16), .MUL_EN(1)) dut16 (.clock(clock), .reset(reset), .bus(b16));
  pipe_alu #(.WIDTH(8),  .MUL_EN(0)) dut8  (.clock(clock), .reset(reset), .bus(b8));

  typedef struct {
    logic [63:0] v;
    int          pres;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int   nvec = 0;
  int   nbad = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the preprocessed operands, truncated to w bits.
  function automatic logic [63:0] ref_alu(input int w, input logic [63:0] xv,
                                          input logic [63:0] yv, input ctrl_t c, input bit m);
    logic [63:0] mask, a, b, r;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = c.zx ? 64'd0 : xv;
    if (c.nx) a = ~a;
    b = c.zy ? 64'd0 : yv;
    if (c.ny) b = ~b;
    if (m)        r = a * b;
    else if (c.f) r = a + b;
    else          r = a & b;
    if (c.no) r = ~r;
    return r & mask;
  endfunction

  task automatic step16(input bit iv, input logic [15:0] xv, input logic [15:0] yv,
                        input ctrl_t c, input bit m, input logic [15:0] ev,
                        input int pct, output bit acc);
    bit   exp_ov, exp_rdy;
    exp_t e;
    @(negedge clock);
    b16.in_valid = iv;
    b16.x = xv;
    b16.y = yv;
    {b16.zx, b16.nx, b16.zy, b16.ny, b16.f, b16.no} = c;
    b16.mul = m;
    b16.out_ready = ($urandom_range(99) < pct);
    #1;
    exp_ov  = (q16.size() > 0) && (q16[0].pres <= cyc);
    exp_rdy = !(cyc >= busy_lo && cyc <= busy_hi) && (!exp_ov || b16.out_ready);
    chk("in_ready", b16.in_ready, exp_rdy);
    acc = iv && exp_rdy;
    if (acc) begin
      e.v    = ev;
      e.pres = cyc + 1 + (m ? 16 : 0);
      q16.push_back(e);
      if (m) begin
        busy_lo = cyc + 1;
        busy_hi = cyc + 16;
      end
    end
  endtask

  task automatic send16(input logic [15:0] xv, input logic [15:0] yv, input ctrl_t c,
                        input bit m, input logic [15:0] ev, input int pct);
    bit a = 1'b0;
    int n = 0;
    while (!a && n < 100) begin
      step16(1'b1, xv, yv, c, m, ev, pct, a);
      n++;
    end
    chk("accepted", a, 1'b1);
  endtask

  task automatic send8(input logic [7:0] xv, input logic [7:0] yv, input ctrl_t c,
                       input bit m, input logic [7:0] ev);
    exp_t e;
    @(negedge clock);
    b8.in_valid = 1'b1;
    b8.x = xv;
    b8.y = yv;
    {b8.zx, b8.nx, b8.zy, b8.ny, b8.f, b8.no} = c;
    b8.mul = m;
    b8.out_ready = 1'b1;
    #1;
    chk("in_ready8", b8.in_ready, 1'b1);
    e.v    = ev;
    e.pres = cyc + 1;
    q8.push_back(e);
  endtask

  // Monitors sample 2 time units after the falling edge, after the drivers.
  initial begin
    bit ev;
    forever begin
      @(negedge clock);
      #2;
      if (mon_en) begin
        ev = (q16.size() > 0) && (q16[0].pres <= cyc);
        chk("out_valid", b16.out_valid, ev);
        chk("busy", b16.busy, (cyc >= busy_lo) && (cyc <= busy_hi));
        if (ev) begin
          chk("out", b16.out, q16[0].v);
          chk("zr", b16.zr, q16[0].v[15:0] == 16'd0);
          chk("ng", b16.ng, q16[0].v[15]);
          if (b16.out_ready) void'(q16.pop_front());
        end
      end
    end
  end

  initial begin
    bit ev;
    forever begin
      @(negedge clock);
      #2;
      if (mon_en) begin
        ev = (q8.size() > 0) && (q8[0].pres <= cyc);
        chk("out_valid8", b8.out_valid, ev);
        chk("busy8", b8.busy, 1'b0);
        if (ev) begin
          chk("out8", b8.out, q8[0].v);
          chk("zr8", b8.zr, q8[0].v[7:0] == 8'd0);
          chk("ng8", b8.ng, q8[0].v[7]);
          if (b8.out_ready) void'(q8.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          a;
    int          t0, n;
    logic [15:0] rx, ry;
    logic [5:0]  r6;
    ctrl_t       c;
    bit          m;

    b16.in_valid = 1'b0; b16.x = '0; b16.y = '0; b16.mul = 1'b0; b16.out_ready = 1'b0;
    {b16.zx, b16.nx, b16.zy, b16.ny, b16.f, b16.no} = X_AND_Y;
    b8.in_valid = 1'b0; b8.x = '0; b8.y = '0; b8.mul = 1'b0; b8.out_ready = 1'b1;
    {b8.zx, b8.nx, b8.zy, b8.ny, b8.f, b8.no} = X_AND_Y;

    #1 reset = 1'b1;
    #2;
    chk("rst_out", b16.out, 16'd0);
    chk("rst_zr", b16.zr, 1'b1);
    chk("rst_ng", b16.ng, 1'b0);
    chk("rst_out_valid", b16.out_valid, 1'b0);
    chk("rst_busy", b16.busy, 1'b0);
    chk("rst_out8", b8.out, 8'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("in_ready_after_rst", b16.in_ready, 1'b1);
    mon_en = 1'b1;

    // Directed ALU ops, issued back to back.
    send16(16'd9, 16'd15, X_PLUS_Y, 1'b0, 16'd24, 100);
    send16(16'd9, 16'd15, X_MINUS_Y, 1'b0, 16'hFFFA, 100);
    send16(16'd9, 16'd15, ZERO, 1'b0, 16'd0, 100);
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      r6 = 6'($urandom_range(63));
      c  = r6;
      send16(rx, ry, c, 1'b0, 16'(ref_alu(16, 64'(rx), 64'(ry), c, 1'b0)), 100);
    end
    chk("b2b_cycles", cyc - t0, 8);

    // Multiplies: f is ignored, 300*300 wraps.
    send16(16'd300, 16'd300, X_AND_Y, 1'b1, 16'd24464, 100);
    send16(16'd9, 16'd15, X_PLUS_Y, 1'b1, 16'd135, 100);

    // Hold a result with out_ready low while new requests keep arriving.
    send16(16'd1234, 16'd4321, X_PLUS_Y, 1'b0, 16'd5555, 100);
    for (int i = 0; i < 5; i++)
      step16(1'b1, 16'($urandom), 16'($urandom), X_PLUS_Y, 1'b0, 16'd0, 0, a);

    // Abort a multiply with reset in its fifth busy cycle.
    send16(16'd9, 16'd15, X_PLUS_Y, 1'b0, 16'd24, 100);
    send16(16'd300, 16'd300, X_PLUS_Y, 1'b1, 16'd24464, 100);
    for (int i = 0; i < 4; i++)
      step16(1'b0, 16'd0, 16'd0, X_AND_Y, 1'b0, 16'd0, 100, a);
    @(negedge clock);
    #3;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_out_valid", b16.out_valid, 1'b0);
    chk("abort_out", b16.out, 16'd0);
    chk("abort_zr", b16.zr, 1'b1);
    chk("abort_ng", b16.ng, 1'b0);
    chk("abort_busy", b16.busy, 1'b0);
    q16.delete();
    busy_lo = 1;
    busy_hi = 0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("in_ready_after_abort", b16.in_ready, 1'b1);
    mon_en = 1'b1;
    send16(16'd9, 16'd15, X_PLUS_Y, 1'b1, 16'd135, 100);

    // Random traffic with random consumer backpressure and idle gaps.
    for (int i = 0; i < 300; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      r6 = 6'($urandom_range(63));
      c  = r6;
      m  = ($urandom_range(3) == 0);
      if ($urandom_range(4) == 0)
        step16(1'b0, rx, ry, c, m, 16'd0, 70, a);
      else
        send16(rx, ry, c, m, 16'(ref_alu(16, 64'(rx), 64'(ry), c, m)), 70);
    end
    n = 0;
    while (q16.size() > 0 && n < 100) begin
      step16(1'b0, 16'd0, 16'd0, X_AND_Y, 1'b0, 16'd0, 100, a);
      n++;
    end
    chk("drain16", q16.size(), 0);

    // 8-bit instance without multiplier: mul is ignored, latency stays 1.
    send8(8'd200, 8'd100, X_PLUS_Y, 1'b0, 8'd44);
    send8(8'd9,   8'd15,  X_PLUS_Y, 1'b1, 8'd24);
    send8(8'd200, 8'd100, X_AND_Y,  1'b1, 8'd64);
    send8(8'd5,   8'd3,   X_MINUS_Y, 1'b0, 8'd2);
    send8(8'd3,   8'd5,   X_MINUS_Y, 1'b0, 8'hFE);
    send8(8'd0,   8'd0,   ONE,       1'b0, 8'd1);
    send8(8'd77,  8'd33,  ZERO,      1'b1, 8'd0);
    @(negedge clock);
    b8.in_valid = 1'b0;
    repeat (3) @(negedge clock);
    #3;
    chk("drain8", q8.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
